// File: rtl/debounce_switch_bank.sv
// N-channel switch debouncer with per-channel two-flop synchroniser, optional
// active-low inversion, registered rise/fall pulses and long-press detection.
module debounce_switch_bank #(
    parameter int unsigned NUM_CH           = 4,
    parameter int unsigned c_DEBOUNCE_LIMIT = 1000000,
    parameter int unsigned c_HOLD_LIMIT     = 100000000,
    parameter bit          ACTIVE_LOW       = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Long
);

    localparam int unsigned CW = (c_DEBOUNCE_LIMIT > 2) ? $clog2(c_DEBOUNCE_LIMIT) : 1;
    localparam int unsigned HW = (c_HOLD_LIMIT > 1) ? $clog2(c_HOLD_LIMIT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(c_DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(c_HOLD_LIMIT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(c_HOLD_LIMIT - 1);

    logic [NUM_CH-1:0] s1_q, s2_q;
    logic [NUM_CH-1:0] sw_q, sw_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] long_q, long_d;
    logic [CW-1:0]     cnt_q  [NUM_CH];
    logic [CW-1:0]     cnt_d  [NUM_CH];
    logic [HW-1:0]     hcnt_q [NUM_CH];
    logic [HW-1:0]     hcnt_d [NUM_CH];

    // Per-channel debounce and hold-time evaluation
    always_comb begin
        sw_d   = sw_q;
        rise_d = '0;
        fall_d = '0;
        long_d = long_q;
        for (int n = 0; n < NUM_CH; n++) begin
            cnt_d[n]  = '0;
            hcnt_d[n] = hcnt_q[n];
            if (s2_q[n] != sw_q[n]) begin
                if (cnt_q[n] == CNT_LAST) begin
                    sw_d[n]   = s2_q[n];
                    rise_d[n] = s2_q[n];
                    fall_d[n] = ~s2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CW'(1);
                end
            end
            // A debounced release wins over the hold count on the same edge
            if (fall_d[n]) begin
                hcnt_d[n] = '0;
                long_d[n] = 1'b0;
            end else if (sw_q[n] && (hcnt_q[n] != HOLD_MAX)) begin
                hcnt_d[n] = hcnt_q[n] + HW'(1);
                if (hcnt_q[n] == HOLD_LAST) begin
                    long_d[n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            sw_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            long_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n]  <= '0;
                hcnt_q[n] <= '0;
            end
        end else begin
            s1_q   <= i_Switch ^ {NUM_CH{ACTIVE_LOW}};
            s2_q   <= s1_q;
            sw_q   <= sw_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            long_q <= long_d;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt_q[n]  <= cnt_d[n];
                hcnt_q[n] <= hcnt_d[n];
            end
        end
    end

    assign o_Switch = sw_q;
    assign o_Rise   = rise_q;
    assign o_Fall   = fall_q;
    assign o_Long   = long_q;

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Directed bench for debounce_switch_bank: DUT a is active-high, DUT b active-low,
// both with 2 channels, debounce limit 4 and hold limit 10.
module tb_debounce_switch_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sw_a = 2'b00;
    logic [1:0] sw_b = 2'b11;
    logic [1:0] osw_a, rise_a, fall_a, long_a;
    logic [1:0] osw_b, rise_b, fall_b, long_b;

    int total = 0;
    int bad   = 0;
    int rises;

    always #5 clk = ~clk;

    debounce_switch_bank #(.NUM_CH(2), .c_DEBOUNCE_LIMIT(4), .c_HOLD_LIMIT(10), .ACTIVE_LOW(1'b0)) u_dut_a (
        .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_a),
        .o_Switch(osw_a), .o_Rise(rise_a), .o_Fall(fall_a), .o_Long(long_a)
    );

    debounce_switch_bank #(.NUM_CH(2), .c_DEBOUNCE_LIMIT(4), .c_HOLD_LIMIT(10), .ACTIVE_LOW(1'b1)) u_dut_b (
        .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_b),
        .o_Switch(osw_b), .o_Rise(rise_b), .o_Fall(fall_b), .o_Long(long_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with both channels of DUT a pressed
        sw_a = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_outs_a", {24'd0, osw_a, rise_a, fall_a, long_a}, 32'd0);
        end
        rst = 1'b0;
        tick(5);
        chk("rst_sw_e5", {30'd0, osw_a}, 32'd0);
        tick(1);
        chk("rst_sw_e6", {30'd0, osw_a}, 32'h3);
        chk("rst_rise_e6", {30'd0, rise_a}, 32'h3);
        chk("lowact_idle", {24'd0, osw_b, rise_b, fall_b, long_b}, 32'd0);
        tick(1);
        chk("rst_rise_e7", {30'd0, rise_a}, 32'd0);

        // Clean press on ch0 from a fresh reset
        rst = 1'b1; sw_a = 2'b00;
        tick(2);
        rst = 1'b0;
        tick(2);
        sw_a = 2'b01;
        tick(5);
        chk("press_e5", {30'd0, osw_a}, 32'd0);
        tick(1);
        chk("press_e6_sw", {30'd0, osw_a}, 32'h1);
        chk("press_e6_rise", {30'd0, rise_a}, 32'h1);
        tick(1);
        chk("press_e7_rise", {30'd0, rise_a}, 32'd0);

        // Short press released before long-press
        sw_a = 2'b00;
        tick(5);
        chk("rel_e5", {30'd0, osw_a}, 32'h1);
        tick(1);
        chk("rel_e6_sw", {30'd0, osw_a}, 32'd0);
        chk("rel_e6_fall", {30'd0, fall_a}, 32'h1);
        chk("rel_e6_long", {30'd0, long_a}, 32'd0);

        // Bounce 1,0,1,0 then steady 1: change six edges after the steady 1 starts
        tick(3);
        rises = 0;
        for (int e = 1; e <= 12; e++) begin
            sw_a[0] = (e >= 5) ? 1'b1 : ((e % 2) == 1);
            tick(1);
            if (rise_a[0]) rises++;
            if (e == 9)  chk("bounce_e9", {31'd0, osw_a[0]}, 32'd0);
            if (e == 10) chk("bounce_e10", {31'd0, osw_a[0]}, 32'd1);
        end
        chk("bounce_rises", 32'(rises), 32'd1);

        // Long-press on ch1
        sw_a[1] = 1'b1;
        tick(6);
        chk("lp_rise", {31'd0, rise_a[1]}, 32'd1);
        tick(9);
        chk("lp_e9", {31'd0, long_a[1]}, 32'd0);
        tick(1);
        chk("lp_e10", {31'd0, long_a[1]}, 32'd1);
        sw_a[1] = 1'b0;
        tick(3);
        sw_a[1] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick(1);
            chk("glitch_hold", {30'd0, osw_a[1], long_a[1]}, 32'h3);
        end
        sw_a[1] = 1'b0;
        tick(5);
        chk("lrel_e5", {29'd0, osw_a[1], fall_a[1], long_a[1]}, 32'h5);
        tick(1);
        chk("lrel_e6", {29'd0, osw_a[1], fall_a[1], long_a[1]}, 32'h2);
        tick(1);
        chk("lrel_e7_fall", {31'd0, fall_a[1]}, 32'd0);

        // Active-low: driving ch0 pin low presses it
        chk("al_before", {30'd0, osw_b}, 32'd0);
        sw_b[0] = 1'b0;
        tick(5);
        chk("al_e5", {30'd0, osw_b}, 32'd0);
        tick(1);
        chk("al_e6", {28'd0, osw_b, rise_b}, 32'h5);
        tick(1);
        chk("al_e7", {28'd0, fall_b, long_b}, 32'd0);

        // Reset mid-count discards progress
        rst = 1'b1; sw_a = 2'b00;
        tick(2);
        rst = 1'b0;
        sw_a = 2'b01;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst", {30'd0, osw_a}, 32'd0);
        rst = 1'b0;
        tick(5);
        chk("mid_e5", {30'd0, osw_a}, 32'd0);
        tick(1);
        chk("mid_e6", {28'd0, osw_a, rise_a}, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_switch_bank.md
Name: debounce_switch_bank

Overview:
Parametrised N-channel debouncer for board buttons and switches (camera capture, mode select, register-load triggers). Each channel has its own input synchroniser, an active-low input option, single-cycle rise and fall pulses, and long-press detection. It sits between the raw FPGA pins and the control FSMs, and replaces the single-channel debouncer in new designs.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
c_DEBOUNCE_LIMIT, 1000000, consecutive mismatch cycles required before the state changes (>=2); 10 ms at 100 MHz
c_HOLD_LIMIT, 100000000, cycles the debounced state must stay 1 before long-press asserts (>=1); 1 s at 100 MHz
ACTIVE_LOW, 0, 1 = input pin reads low when pressed, so the input is inverted before synchronisation

Ports:
i_Clk  in  1  system clock; all logic on the rising edge
i_Reset  in  1  synchronous, active-high reset
i_Switch  in  NUM_CH  raw asynchronous switch inputs, one bit per channel
o_Switch  out  NUM_CH  debounced state; 1 = pressed/on after polarity correction
o_Rise  out  NUM_CH  one-cycle pulse when o_Switch goes 0->1
o_Fall  out  NUM_CH  one-cycle pulse when o_Switch goes 1->0
o_Long  out  NUM_CH  level; 1 while o_Switch has been 1 for >= c_HOLD_LIMIT cycles

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous, active-high, on i_Reset.
- Reset: all of the following clear to 0 on the reset edge: sync flops, o_Switch, o_Rise, o_Fall, o_Long, and all counters. Reset mid-count discards progress. The first evaluation happens on the edge after i_Reset deasserts.
- Channels are fully independent. Per channel:
  - Polarity: p = i_Switch[n] ^ ACTIVE_LOW.
  - Synchroniser: two flops, s1 <= p and s2 <= s1. Only s2 feeds the debounce logic.
- Debounce counter: width $clog2(c_DEBOUNCE_LIMIT). Evaluated every edge, in priority order:
  1. s2 != state and cnt < c_DEBOUNCE_LIMIT-1 -> cnt <= cnt+1.
  2. s2 != state and cnt == c_DEBOUNCE_LIMIT-1 -> state <= s2, cnt <= 0, and the matching edge pulse asserts on this same edge.
  3. s2 == state -> cnt <= 0. Any glitch restarts the count.
- Latency: p changes and holds steady -> o_Switch changes on the (c_DEBOUNCE_LIMIT+2)th rising edge after the first edge that samples the new p. That is 2 edges for the synchroniser plus c_DEBOUNCE_LIMIT mismatch edges.
- Edge pulses: o_Rise and o_Fall are registered, exactly 1 cycle high, and coincident with the o_Switch transition. They are never high together.
- Long-press:
  - Hold counter width: $clog2(c_HOLD_LIMIT+1).
  - While o_Switch == 1 and hcnt < c_HOLD_LIMIT: hcnt <= hcnt+1.
  - When hcnt reaches c_HOLD_LIMIT, o_Long <= 1. The counter saturates, with no wrap and no repeat.
  - Result: o_Long rises c_HOLD_LIMIT edges after o_Switch rises.
  - On the edge where o_Switch falls: hcnt <= 0 and o_Long <= 0 on that same edge.
  - A release shorter than c_DEBOUNCE_LIMIT never reaches o_Switch, so it does not clear hcnt.
- Simultaneous events: several channels may transition on the same edge; each produces its own pulses. While the state change is taken, the input mismatch that caused it clears the counter.
- No combinational path from any input to any output.
- Resource target: NUM_CH x (2 + 1 + 3 output flops + both counters).

Test Plan:
1. Reset: NUM_CH=2, c_DEBOUNCE_LIMIT=4, c_HOLD_LIMIT=10. Assert i_Reset for 3 cycles with i_Switch=2'b11 -> all outputs stay 0 during reset; after release o_Switch=2'b11 at edge 6, with o_Rise=2'b11 for that one cycle.
2. Clean press on ch0 at edge 0 -> o_Switch[0]=1 and o_Rise[0]=1 at edge 6; o_Rise[0]=0 at edge 7; ch1 unchanged.
3. Bounce: ch0 toggles 1,0,1,0 on successive edges, then holds 1 -> no o_Switch change until 6 edges after the final steady 1; exactly one o_Rise pulse.
4. Long-press: hold ch1 pressed -> o_Long[1]=1 exactly 10 edges after o_Rise[1]. Release -> o_Fall[1] and o_Long[1]=0 on the same edge, 6 edges after release. A 3-cycle release glitch during the hold leaves o_Long[1]=1.
5. ACTIVE_LOW=1: i_Switch=2'b11 from reset -> o_Switch=2'b00, no pulses. Drive ch0 to 0 -> o_Switch[0]=1 after 6 edges.
6. Reset mid-count: ch0 pressed, i_Reset pulsed at edge 4 (counter=2) -> counts restart. o_Switch[0]=1 six edges after reset release, not earlier.
